int_writeback_arbiter: RTL and testbench
========================================

# int_writeback_arbiter

Writeback stage directly upstream of the integer register file. It merges two result sources into the register file's single write port: the in-order single-cycle ALU pipeline and a long-latency return path (loads, multiply/divide). Long-latency results are buffered in a small FIFO and drained on cycles when the ALU leaves the port free. A per-register pending mask is exported so decode can stall on RAW and WAW hazards.

## Interface
- DATA_W, 32, result width
- ADDR_W, 5, register address width
- DEPTH, 4, long-path FIFO entries; must be a power of two and at least 2
- clk_i  in  1  clock, rising edge
- rsn_i  in  1  reset; asynchronous assert, active-low
- alu_valid_i  in  1  ALU result present this cycle
- alu_addr_i  in  ADDR_W  ALU destination register
- alu_data_i  in  DATA_W  ALU result
- alu_ready_o  out  1  ALU result accepted this cycle; equals !stall_o
- long_valid_i  in  1  long-latency result offered
- long_ready_o  out  1  FIFO can accept; equals (count != DEPTH)
- long_addr_i  in  ADDR_W  long-latency destination register
- long_data_i  in  DATA_W  long-latency result
- stall_o  out  1  FIFO full; pipeline must hold its ALU result
- wb_we_o  out  1  register-file write enable, registered
- wb_addr_o  out  ADDR_W  register-file write address, registered
- wb_data_o  out  DATA_W  register-file write data, registered
- pend_mask_o  out  2^ADDR_W  bit r set while a write to register r is queued or on the wb_* outputs

## Operation
- **Storage.** A circular FIFO holds (addr, data) entries.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - The occupancy count is log2(DEPTH)+1 bits, ranging 0..DEPTH.
- **Long-path handshake.** A long-path transfer occurs on an edge where long_valid_i && long_ready_o.
  - If long_addr_i != 0, the entry is enqueued.
  - If long_addr_i == 0, the transfer is accepted and discarded; count is unchanged.
- **ALU path.** An ALU transfer occurs on an edge where alu_valid_i && alu_ready_o.
  - The ALU has no FIFO; its result goes straight to the wb registers.
- **Port selection, evaluated each cycle in priority order:**
  - stall_o = 1: the FIFO head drains. ALU input is ignored, and upstream holds alu_valid_i, alu_addr_i and alu_data_i stable.
  - Otherwise, ALU transfer with alu_addr_i != 0: the ALU result is written and the FIFO does not drain.
  - Otherwise, FIFO not empty: the head drains. This includes ALU writes to x0, which are dropped.
  - Otherwise: wb_we_o = 0 on the next cycle.
- **Simultaneous enqueue and dequeue** on one edge: count is unchanged and both pointers advance. This cannot happen while full, because long_ready_o = 0.
- **stall_o** = (count == DEPTH), decoded from registered state with no combinational path from inputs. It stays high until the drain edge makes count = DEPTH-1.
- **pend_mask_o** is combinational: OR over the valid FIFO entries of onehot(addr), plus onehot(wb_addr_o) when wb_we_o = 1. Bit 0 is always 0.
- **Ordering.**
  - FIFO entries drain in arrival order.
  - No WAW reordering check is done between the ALU and FIFO paths; decode must not issue an ALU write to a register whose pend_mask_o bit is set.
  - FIFO entries to the same register keep program order.
- **Reset (rsn_i = 0), asynchronous:**
  - count, both pointers, wb_we_o, wb_addr_o and wb_data_o clear to 0.
  - FIFO contents are discarded, including mid-drain.
  - During reset: stall_o = 0, alu_ready_o = 1, long_ready_o = 1, pend_mask_o = 0.

## Timing
- ALU latency: accepted at edge E, wb_* valid during the cycle after E, so the register file writes at E+1.
- Long latency, minimum: enqueued at edge E, drained at E+1, wb_* valid after E+1.
  - That is two edges, plus one edge for every cycle the ALU holds the port.
- Throughput: one register-file write per cycle.
  - The FIFO drains only on ALU bubbles, x0 ALU writes, or stall cycles.
- Starvation bound: with the FIFO full, the next cycle is guaranteed a drain.
- stall_o, long_ready_o and alu_ready_o depend on registered state only.

## Test plan
- **Reset values.** Hold rsn_i low, then release.
  - Required: wb_we_o = 0, stall_o = 0, long_ready_o = 1, pend_mask_o = 0.
  - Assert rsn_i low mid-drain: all of the above clear immediately, without waiting for a clock edge.
- **ALU-only stream.** x1 = 0x11, x2 = 0x22, x3 = 0x33 on consecutive cycles.
  - Required: wb_* shows each write exactly one cycle later, in order.
  - Required: pend_mask_o shows bits 1, 2, 3 only while each write is on the wb outputs.
- **Long result in an idle pipeline.** Long x5 = 0xDEADBEEF with no ALU traffic.
  - Required: wb_we_o = 1, addr 5, after the second edge.
  - Required: pend_mask_o[5] is set from the accept edge until the cycle after the write.
- **Fill and stall.** ALU writes x1..x8 continuously while 4 long results (x10..x13) arrive.
  - Required: count reaches 4, stall_o = 1, long_ready_o = 0.
  - Required: the next cycle drains x10 while the held ALU write waits; stall_o then drops and the ALU write completes the following cycle.
- **x0 handling.**
  - A long write to x0 is accepted with count unchanged.
  - An ALU write to x0 with the FIFO holding x7 drains x7 in that cycle; wb_addr_o is never 0 with wb_we_o = 1.
- **Simultaneous enqueue and dequeue.** Count = 2, ALU idle, long x9 arriving.
  - Required: count stays 2, the head drains, x9 is written 2 cycles later, and pointers wrap correctly past DEPTH-1.

Source files
------------

// File: rtl/int_writeback_arbiter.sv
// int_writeback_arbiter
// Merges the single-cycle ALU result stream and a buffered long-latency return
// path onto the register file's one write port. A pending-write mask is exported
// so decode can detect RAW and WAW hazards.
//
// Ports:
//   clk_i, rsn_i                      clock, async active-low reset
//   alu_valid_i/addr_i/data_i         ALU result (held by upstream while stalled)
//   alu_ready_o                       ALU result accepted this cycle (= !stall_o)
//   long_valid_i/addr_i/data_i        long-latency result offer
//   long_ready_o                      FIFO has room
//   stall_o                           FIFO full; next cycle drains the FIFO head
//   wb_we_o/addr_o/data_o             registered register-file write port
//   pend_mask_o                       per-register queued-or-writing mask
module int_writeback_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rsn_i,
    input  logic                    alu_valid_i,
    input  logic [ADDR_W-1:0]       alu_addr_i,
    input  logic [DATA_W-1:0]       alu_data_i,
    output logic                    alu_ready_o,
    input  logic                    long_valid_i,
    output logic                    long_ready_o,
    input  logic [ADDR_W-1:0]       long_addr_i,
    input  logic [DATA_W-1:0]       long_data_i,
    output logic                    stall_o,
    output logic                    wb_we_o,
    output logic [ADDR_W-1:0]       wb_addr_o,
    output logic [DATA_W-1:0]       wb_data_o,
    output logic [(2**ADDR_W)-1:0]  pend_mask_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_wb_we;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_full;
    logic              w_empty;
    logic              w_enq;
    logic              w_alu_wr;
    logic              w_deq;
    logic [NREG-1:0]   w_pend;
    logic [PTR_W-1:0]  w_idx;

    // Handshake and port-selection decode; ready/stall come from registered count only.
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign stall_o      = w_full;
    assign alu_ready_o  = !w_full;
    assign long_ready_o = !w_full;
    // Writes to x0 are accepted but never reach the FIFO or the write port.
    assign w_enq        = long_valid_i && !w_full && (long_addr_i != '0);
    assign w_alu_wr     = alu_valid_i && !w_full && (alu_addr_i != '0);
    // Full always drains; otherwise the FIFO only gets the port when the ALU leaves it.
    assign w_deq        = w_full || (!w_alu_wr && !w_empty);

    // Pointers, occupancy and registered write port.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            if (w_deq) begin
                r_wb_we   <= 1'b1;
                r_wb_addr <= r_addr_mem[r_rd_ptr];
                r_wb_data <= r_data_mem[r_rd_ptr];
            end else if (w_alu_wr) begin
                r_wb_we   <= 1'b1;
                r_wb_addr <= alu_addr_i;
                r_wb_data <= alu_data_i;
            end else begin
                r_wb_we   <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset since validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_addr_mem[r_wr_ptr] <= long_addr_i;
            r_data_mem[r_wr_ptr] <= long_data_i;
        end
    end

    // Pending mask: every valid FIFO entry plus the write currently on the port.
    always_comb begin
        w_pend = '0;
        w_idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < r_count) w_pend[r_addr_mem[w_idx]] = 1'b1;
        end
        if (r_wb_we) w_pend[r_wb_addr] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign pend_mask_o = w_pend;
    assign wb_we_o     = r_wb_we;
    assign wb_addr_o   = r_wb_addr;
    assign wb_data_o   = r_wb_data;

endmodule

// File: tb/tb_int_writeback_arbiter.sv
// Directed bench for int_writeback_arbiter: a per-cycle vector table covering the
// ALU stream, idle long return, fill/stall, x0 handling and simultaneous
// enqueue/dequeue with pointer wrap, plus hand sequences for reset behaviour.
module tb_int_writeback_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NREG   = 32;

    logic              clk_i = 1'b0;
    logic              rsn_i;
    logic              alu_valid_i;
    logic [ADDR_W-1:0] alu_addr_i;
    logic [DATA_W-1:0] alu_data_i;
    logic              alu_ready_o;
    logic              long_valid_i;
    logic              long_ready_o;
    logic [ADDR_W-1:0] long_addr_i;
    logic [DATA_W-1:0] long_data_i;
    logic              stall_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [NREG-1:0]   pend_mask_o;

    int checks = 0;
    int errors = 0;

    int_writeback_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .alu_ready_o(alu_ready_o),
        .long_valid_i(long_valid_i), .long_ready_o(long_ready_o),
        .long_addr_i(long_addr_i), .long_data_i(long_data_i),
        .stall_o(stall_o),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .pend_mask_o(pend_mask_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              lv;
        logic [ADDR_W-1:0] la;
        logic [DATA_W-1:0] ld;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              st;
        logic [NREG-1:0]   pm;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [NREG-1:0] b(input int n);
        return NREG'(1) << n;
    endfunction

    function automatic vec_t mk(input int av, input int aa, input logic [31:0] ad,
                                input int lv, input int la, input logic [31:0] ld,
                                input int we, input int wa, input logic [31:0] wd,
                                input int st, input logic [NREG-1:0] pm);
        vec_t v;
        v.av = 1'(av); v.aa = ADDR_W'(aa); v.ad = ad;
        v.lv = 1'(lv); v.la = ADDR_W'(la); v.ld = ld;
        v.we = 1'(we); v.wa = ADDR_W'(wa); v.wd = wd;
        v.st = 1'(st); v.pm = pm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
        alu_valid_i  = av; alu_addr_i  = aa; alu_data_i  = ad;
        long_valid_i = lv; long_addr_i = la; long_data_i = ld;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " we"},         64'(wb_we_o),      64'(0));
        chk({tag, " stall"},      64'(stall_o),      64'(0));
        chk({tag, " long_ready"}, 64'(long_ready_o), 64'(1));
        chk({tag, " alu_ready"},  64'(alu_ready_o),  64'(1));
        chk({tag, " pend"},       64'(pend_mask_o),  64'(0));
    endtask

    initial begin
        // ALU-only stream
        vecs.push_back(mk(1,1,32'h11, 0,0,0,          1,1,32'h11, 0, b(1)));
        vecs.push_back(mk(1,2,32'h22, 0,0,0,          1,2,32'h22, 0, b(2)));
        vecs.push_back(mk(1,3,32'h33, 0,0,0,          1,3,32'h33, 0, b(3)));
        vecs.push_back(mk(0,0,0,      0,0,0,          0,0,0,      0, '0));
        // Long result into an idle pipeline
        vecs.push_back(mk(0,0,0,      1,5,32'hDEADBEEF, 0,0,0,    0, b(5)));
        vecs.push_back(mk(0,0,0,      0,0,0,          1,5,32'hDEADBEEF, 0, b(5)));
        vecs.push_back(mk(0,0,0,      0,0,0,          0,0,0,      0, '0));
        // Fill and stall: ALU keeps the port while x10..x13 queue up
        vecs.push_back(mk(1,1,32'h101, 1,10,32'hA0,   1,1,32'h101, 0, b(1)|b(10)));
        vecs.push_back(mk(1,2,32'h102, 1,11,32'hA1,   1,2,32'h102, 0, b(2)|b(10)|b(11)));
        vecs.push_back(mk(1,3,32'h103, 1,12,32'hA2,   1,3,32'h103, 0, b(3)|b(10)|b(11)|b(12)));
        vecs.push_back(mk(1,4,32'h104, 1,13,32'hA3,   1,4,32'h104, 1, b(4)|b(10)|b(11)|b(12)|b(13)));
        // Full: head drains, held ALU x5 and offered x14 both refused
        vecs.push_back(mk(1,5,32'h105, 1,14,32'hA4,   1,10,32'hA0, 0, b(10)|b(11)|b(12)|b(13)));
        vecs.push_back(mk(1,5,32'h105, 1,14,32'hA4,   1,5,32'h105, 1, b(5)|b(11)|b(12)|b(13)|b(14)));
        vecs.push_back(mk(1,6,32'h106, 0,0,0,         1,11,32'hA1, 0, b(11)|b(12)|b(13)|b(14)));
        vecs.push_back(mk(1,6,32'h106, 0,0,0,         1,6,32'h106, 0, b(6)|b(12)|b(13)|b(14)));
        vecs.push_back(mk(0,0,0,       0,0,0,         1,12,32'hA2, 0, b(12)|b(13)|b(14)));
        vecs.push_back(mk(0,0,0,       0,0,0,         1,13,32'hA3, 0, b(13)|b(14)));
        // x0 handling: long x0 discarded, then ALU x0 lets x7 drain
        vecs.push_back(mk(0,0,0,       1,0,32'hBAD,   1,14,32'hA4, 0, b(14)));
        vecs.push_back(mk(0,0,0,       1,7,32'h77,    0,0,0,       0, b(7)));
        vecs.push_back(mk(1,0,32'h999, 0,0,0,         1,7,32'h77,  0, b(7)));
        vecs.push_back(mk(0,0,0,       0,0,0,         0,0,0,       0, '0));
        // Simultaneous enqueue/dequeue at count 2, pointers wrapping
        vecs.push_back(mk(1,1,32'h201, 1,20,32'hC0,   1,1,32'h201, 0, b(1)|b(20)));
        vecs.push_back(mk(1,2,32'h202, 1,21,32'hC1,   1,2,32'h202, 0, b(2)|b(20)|b(21)));
        vecs.push_back(mk(0,0,0,       1,9,32'h99,    1,20,32'hC0, 0, b(9)|b(20)|b(21)));
        vecs.push_back(mk(0,0,0,       0,0,0,         1,21,32'hC1, 0, b(9)|b(21)));
        vecs.push_back(mk(0,0,0,       0,0,0,         1,9,32'h99,  0, b(9)));
        vecs.push_back(mk(0,0,0,       0,0,0,         0,0,0,       0, '0));

        // Reset values
        rsn_i = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_state("in_reset");
        @(negedge clk_i);
        rsn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk_reset_state("post_reset");

        // Table-driven per-cycle vectors
        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d we", i),         64'(wb_we_o),      64'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("v%0d addr", i),   64'(wb_addr_o),    64'(vecs[i].wa));
                chk($sformatf("v%0d data", i),   64'(wb_data_o),    64'(vecs[i].wd));
            end
            chk($sformatf("v%0d stall", i),      64'(stall_o),      64'(vecs[i].st));
            chk($sformatf("v%0d long_ready", i), 64'(long_ready_o), 64'(!vecs[i].st));
            chk($sformatf("v%0d alu_ready", i),  64'(alu_ready_o),  64'(!vecs[i].st));
            chk($sformatf("v%0d pend", i),       64'(pend_mask_o),  64'(vecs[i].pm));
        end

        // Reset asserted mid-drain with the FIFO full
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            drive(1'b1, ADDR_W'(k + 1), DATA_W'(32'h300 + k), 1'b1, ADDR_W'(k + 16), DATA_W'(32'hE0 + k));
        end
        @(posedge clk_i);
        #1;
        chk("full_before_reset stall", 64'(stall_o), 64'(1));
        chk("full_before_reset we",    64'(wb_we_o), 64'(1));
        #2;
        rsn_i = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(negedge clk_i);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        rsn_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("after_reset%0d we", k),    64'(wb_we_o),     64'(0));
            chk($sformatf("after_reset%0d pend", k),  64'(pend_mask_o), 64'(0));
            chk($sformatf("after_reset%0d stall", k), 64'(stall_o),     64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
